// File: rtl/fcvt_pkg.sv
// Shared types and constants for the float-to-int converter arbiter.
package fcvt_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_t;

    localparam int unsigned DEFAULT_TIMEOUT = 64;
    localparam logic [31:0] ERR_RESULT      = 32'h0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first valid index strictly after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            grant_any
);

    localparam int unsigned CW = IDXW + 1;

    logic [CW-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            // One extra bit so ptr+off cannot overflow before the wrap.
            cand = {1'b0, ptr} + CW'(off);
            if (cand >= CW'(NREQ)) begin
                cand = cand - CW'(NREQ);
            end
            if (!grant_any && valid[cand[IDXW-1:0]]) begin
                grant_any                = 1'b1;
                grant[cand[IDXW-1:0]]    = 1'b1;
                grant_idx                = cand[IDXW-1:0];
            end
        end
    end

endmodule

// File: rtl/fcvt_arbiter.sv
// Shares one single-shot float_to_int converter between NREQ requesters with
// round-robin grant, one conversion in flight, tag echo and a timeout watchdog.
module fcvt_arbiter
    import fcvt_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TAGW    = 4,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*32-1:0]        req_a,
    input  logic [NREQ*TAGW-1:0]      req_tag,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_z,
    output logic [$clog2(NREQ)-1:0]   rsp_src,
    output logic [TAGW-1:0]           rsp_tag,
    output logic                      rsp_err,
    output logic [31:0]               cvt_a,
    output logic                      cvt_rst,
    input  logic [31:0]               cvt_z,
    input  logic                      cvt_stb
);

    localparam int unsigned IDXW = $clog2(NREQ);
    localparam int unsigned CNTW = $clog2(TIMEOUT);

    state_t              state_q, state_d;
    logic [IDXW-1:0]     rr_q, rr_d;
    logic [IDXW-1:0]     src_q, src_d;
    logic [TAGW-1:0]     tag_q, tag_d;
    logic [31:0]         cvt_a_q, cvt_a_d;
    logic [31:0]         z_q, z_d;
    logic                err_q, err_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;

    logic [NREQ-1:0]     grant;
    logic [IDXW-1:0]     grant_idx;
    logic                grant_any;
    logic                timeout_hit;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr (
        .valid     (req_valid),
        .ptr       (rr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign timeout_hit = (cnt_q == CNTW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= IDXW'(NREQ - 1);
            src_q   <= '0;
            tag_q   <= '0;
            cvt_a_q <= '0;
            z_q     <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            src_q   <= src_d;
            tag_q   <= tag_d;
            cvt_a_q <= cvt_a_d;
            z_q     <= z_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (grant_any) state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT:   if (cvt_stb || timeout_hit) state_d = S_RESP;
            S_RESP:   if (rsp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rr_d    = rr_q;
        src_d   = src_q;
        tag_d   = tag_q;
        cvt_a_d = cvt_a_q;
        z_d     = z_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    rr_d    = grant_idx;
                    src_d   = grant_idx;
                    cvt_a_d = req_a[int'(grant_idx)*32 +: 32];
                    tag_d   = req_tag[int'(grant_idx)*TAGW +: TAGW];
                end
            end
            S_LAUNCH: cnt_d = '0;
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A strobe on the timeout cycle still counts as a good result.
                if (cvt_stb) begin
                    z_d   = cvt_z;
                    err_d = 1'b0;
                end else if (timeout_hit) begin
                    z_d   = ERR_RESULT;
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        cvt_rst   = 1'b1;
        case (state_q)
            S_IDLE:  if (!rst) req_ready = grant;
            S_WAIT:  cvt_rst = 1'b0;
            S_RESP:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign rsp_z   = z_q;
    assign rsp_src = src_q;
    assign rsp_tag = tag_q;
    assign rsp_err = err_q;
    assign cvt_a   = cvt_a_q;

endmodule

// File: tb/tb_fcvt_arbiter.sv
// Bench for fcvt_arbiter: converter stub plus response scoreboard.
module tb_fcvt_arbiter;

    localparam int unsigned NREQ    = 2;
    localparam int unsigned TAGW    = 4;
    localparam int unsigned TIMEOUT = 64;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_a;
    logic [NREQ*TAGW-1:0] req_tag;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_z;
    logic [0:0]           rsp_src;
    logic [TAGW-1:0]      rsp_tag;
    logic                 rsp_err;
    logic [31:0]          cvt_a;
    logic                 cvt_rst;
    logic [31:0]          cvt_z;
    logic                 cvt_stb;

    typedef struct packed {
        logic [31:0]     z;
        logic [0:0]      src;
        logic [TAGW-1:0] tag;
        logic            err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;
    int unsigned stub_k = 0;
    logic        stub_never = 1'b0;
    int unsigned stub_cnt = 0;

    always #5 clk = ~clk;

    fcvt_arbiter #(
        .NREQ    (NREQ),
        .TAGW    (TAGW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .rsp_src   (rsp_src),
        .rsp_tag   (rsp_tag),
        .rsp_err   (rsp_err),
        .cvt_a     (cvt_a),
        .cvt_rst   (cvt_rst),
        .cvt_z     (cvt_z),
        .cvt_stb   (cvt_stb)
    );

    // Truncating float->int, enough for the operands used here.
    function automatic logic [31:0] f2i(input logic [31:0] a);
        logic [7:0]  e;
        logic [31:0] m;
        logic [31:0] v;
        e = a[30:23];
        m = {8'd0, 1'b1, a[22:0]};
        if (e < 8'd127) return 32'd0;
        if (e > 8'd157) return 32'h8000_0000;
        if (e >= 8'd150) v = m << (e - 8'd150);
        else             v = m >> (8'd150 - e);
        return a[31] ? -v : v;
    endfunction

    // Converter stub: strobes k cycles after its reset is released.
    always @(posedge clk) begin
        if (cvt_rst) stub_cnt <= 0;
        else         stub_cnt <= stub_cnt + 1;
    end
    assign cvt_stb = !cvt_rst && !stub_never && (stub_cnt == stub_k);
    assign cvt_z   = f2i(cvt_a);

    always @(negedge clk) begin
        #2;
        if (!rst && rsp_valid && rsp_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: got z=%h src=%0d tag=%h err=%b, required no response",
                         rsp_z, rsp_src, rsp_tag, rsp_err);
            end else begin
                mon_e = sb.pop_front();
                if ({rsp_z, rsp_src, rsp_tag, rsp_err} !== mon_e) begin
                    bad++;
                    $display("FAIL rsp_data: got z=%h src=%0d tag=%h err=%b required z=%h src=%0d tag=%h err=%b",
                             rsp_z, rsp_src, rsp_tag, rsp_err, mon_e.z, mon_e.src, mon_e.tag, mon_e.err);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b11; req_a = '0; req_tag = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({req_ready, rsp_valid, cvt_rst, cvt_a, rsp_z, rsp_src, rsp_tag, rsp_err} !==
            {2'b00, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs: got ready=%b vld=%b crst=%b a=%h z=%h src=%0d tag=%h err=%b required 00 0 1 0 0 0 0 0",
                     req_ready, rsp_valid, cvt_rst, cvt_a, rsp_z, rsp_src, rsp_tag, rsp_err);
        end
        @(negedge clk); req_valid = '0; rst = 1'b0;
    endtask

    task automatic test_single();
        int unsigned cyc;
        stub_k = 5; stub_never = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        req_a[31:0] = 32'h4000_0000; req_tag[3:0] = 4'd3; req_valid = 2'b01;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++; $display("FAIL single_grant: got %b required 01", req_ready);
        end
        sb.push_back('{32'd2, 1'b0, 4'd3, 1'b0});
        cyc = 0;
        do begin
            @(negedge clk); cyc++;
            if (cyc == 1) req_valid = '0;
            #1;
        end while (!rsp_valid && cyc < 200);
        total++;
        if (cyc != 8) begin
            bad++; $display("FAIL single_latency: got %0d required 8", cyc);
        end
        @(negedge clk); #1;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL single_rsp_drop: got %b required 0", rsp_valid);
        end
    endtask

    task automatic test_negative();
        int unsigned cyc;
        stub_k = 2; rsp_ready = 1'b1;
        @(negedge clk);
        req_a[63:32] = 32'hc0e0_0000; req_tag[7:4] = 4'd9; req_valid = 2'b10;
        #1;
        total++;
        if (req_ready !== 2'b10) begin
            bad++; $display("FAIL neg_grant: got %b required 10", req_ready);
        end
        sb.push_back('{32'hFFFF_FFF9, 1'b1, 4'd9, 1'b0});
        cyc = 0;
        do begin
            @(negedge clk); cyc++;
            if (cyc == 1) req_valid = '0;
            #1;
            if (cyc == 1) begin
                total++;
                if ({cvt_rst, cvt_a} !== {1'b1, 32'hc0e0_0000}) begin
                    bad++; $display("FAIL neg_launch: got rst=%b a=%h required 1 c0e00000", cvt_rst, cvt_a);
                end
            end
            if (cyc == 2) begin
                total++;
                if ({cvt_rst, cvt_a} !== {1'b0, 32'hc0e0_0000}) begin
                    bad++; $display("FAIL neg_release: got rst=%b a=%h required 0 c0e00000", cvt_rst, cvt_a);
                end
            end
        end while (!rsp_valid && cyc < 200);
        total++;
        if (cyc != 5) begin
            bad++; $display("FAIL neg_latency: got %0d required 5", cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic [31:0] a0 [4] = '{32'h3f80_0000, 32'h4060_0000, 32'h42c8_0000, 32'hbfc0_0000};
        logic [31:0] z0 [4] = '{32'd1, 32'd3, 32'd100, 32'hFFFF_FFFF};
        logic [31:0] a1 [4] = '{32'h447a_0000, 32'h3f00_0000, 32'hc0e0_0000, 32'h4000_0000};
        logic [31:0] z1 [4] = '{32'd1000, 32'd0, 32'hFFFF_FFF9, 32'd2};
        int unsigned n0 = 0, n1 = 0, grants = 0, cyc = 0;
        logic [1:0]  exp_g = 2'b01;
        stub_k = 1; rsp_ready = 1'b1;
        while (grants < 8 && cyc < 600) begin
            @(negedge clk); cyc++;
            if (n0 < 4) begin req_a[31:0]  = a0[n0]; req_tag[3:0] = 4'(n0);     end
            if (n1 < 4) begin req_a[63:32] = a1[n1]; req_tag[7:4] = 4'(8 + n1); end
            req_valid = {n1 < 4, n0 < 4};
            #1;
            if (req_ready != 2'b00) begin
                total++;
                if (req_ready !== exp_g) begin
                    bad++; $display("FAIL contention_order: grant %0d got %b required %b", grants, req_ready, exp_g);
                end
                if (req_ready[0]) begin sb.push_back('{z0[n0], 1'b0, 4'(n0), 1'b0});     n0++; end
                else              begin sb.push_back('{z1[n1], 1'b1, 4'(8 + n1), 1'b0}); n1++; end
                exp_g = {exp_g[0], exp_g[1]};
                grants++;
            end
        end
        total++;
        if (grants != 8) begin
            bad++; $display("FAIL contention_grants: got %0d required 8", grants);
        end
        @(negedge clk); req_valid = '0;
        cyc = 0;
        while (sb.size() != 0 && cyc < 200) begin @(negedge clk); cyc++; end
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL contention_drain: got %0d pending required 0", sb.size());
        end
    endtask

    task automatic test_backpressure();
        int unsigned cyc;
        stub_k = 0; rsp_ready = 1'b0;
        @(negedge clk);
        req_a = {32'h42c8_0000, 32'h4000_0000}; req_tag = {4'd6, 4'd5}; req_valid = 2'b11;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++; $display("FAIL bp_grant: got %b required 01", req_ready);
        end
        sb.push_back('{32'd2, 1'b0, 4'd5, 1'b0});
        cyc = 0;
        do begin
            @(negedge clk); cyc++;
            if (cyc == 1) req_valid = 2'b10;
            #1;
        end while (!rsp_valid && cyc < 200);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            total++;
            if ({rsp_valid, req_ready, cvt_rst, rsp_z, rsp_src, rsp_tag, rsp_err} !==
                {1'b1, 2'b00, 1'b1, 32'd2, 1'b0, 4'd5, 1'b0}) begin
                bad++;
                $display("FAIL bp_hold: cycle %0d got vld=%b ready=%b crst=%b z=%h src=%0d tag=%h err=%b required 1 00 1 2 0 5 0",
                         i, rsp_valid, req_ready, cvt_rst, rsp_z, rsp_src, rsp_tag, rsp_err);
            end
        end
        @(negedge clk); rsp_ready = 1'b1; #1;
        total++;
        if ({rsp_valid, req_ready} !== {1'b1, 2'b00}) begin
            bad++; $display("FAIL bp_handshake_nogrant: got vld=%b ready=%b required 1 00", rsp_valid, req_ready);
        end
        @(negedge clk); #1;
        total++;
        if ({rsp_valid, req_ready} !== {1'b0, 2'b10}) begin
            bad++; $display("FAIL bp_next_grant: got vld=%b ready=%b required 0 10", rsp_valid, req_ready);
        end
        sb.push_back('{32'd100, 1'b1, 4'd6, 1'b0});
        @(negedge clk); req_valid = '0;
        cyc = 0;
        while (sb.size() != 0 && cyc < 200) begin @(negedge clk); cyc++; end
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL bp_drain: got %0d pending required 0", sb.size());
        end
    endtask

    task automatic test_timeout();
        int unsigned cyc;
        stub_never = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        req_a[63:32] = 32'h4000_0000; req_tag[7:4] = 4'hA; req_valid = 2'b10;
        sb.push_back('{32'd0, 1'b1, 4'hA, 1'b1});
        cyc = 0;
        do begin
            @(negedge clk); cyc++;
            if (cyc == 1) req_valid = '0;
            #1;
        end while (!rsp_valid && cyc < 300);
        total++;
        if (cyc != 2 + TIMEOUT) begin
            bad++; $display("FAIL timeout_latency: got %0d required %0d", cyc, 2 + TIMEOUT);
        end
        @(negedge clk);
        stub_never = 1'b0; stub_k = 3;
        req_a[31:0] = 32'h447a_0000; req_tag[3:0] = 4'd2; req_valid = 2'b01;
        sb.push_back('{32'd1000, 1'b0, 4'd2, 1'b0});
        cyc = 0;
        do begin
            @(negedge clk); cyc++;
            if (cyc == 1) req_valid = '0;
            #1;
        end while (!rsp_valid && cyc < 200);
        total++;
        if (cyc != 6) begin
            bad++; $display("FAIL timeout_recover_latency: got %0d required 6", cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int unsigned cyc;
        int unsigned stale = 0;
        stub_never = 1'b1; stub_k = 0; rsp_ready = 1'b1;
        @(negedge clk);
        req_a[63:32] = 32'h3f80_0000; req_tag[7:4] = 4'd7; req_valid = 2'b10;
        @(negedge clk); req_valid = '0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (cvt_rst !== 1'b0) begin
            bad++; $display("FAIL arst_in_wait: got cvt_rst=%b required 0", cvt_rst);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({req_ready, rsp_valid, cvt_rst, cvt_a, rsp_z, rsp_src, rsp_tag, rsp_err} !==
            {2'b00, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0}) begin
            bad++;
            $display("FAIL arst_outputs: got ready=%b vld=%b crst=%b a=%h z=%h src=%0d tag=%h err=%b required 00 0 1 0 0 0 0 0",
                     req_ready, rsp_valid, cvt_rst, cvt_a, rsp_z, rsp_src, rsp_tag, rsp_err);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0; stub_never = 1'b0;
        for (cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk); #1;
            if (rsp_valid) stale++;
        end
        total++;
        if (stale != 0) begin
            bad++; $display("FAIL arst_stale_rsp: got %0d valid cycles required 0", stale);
        end
        @(negedge clk);
        req_a = {32'h4000_0000, 32'h3f80_0000}; req_tag = {4'd4, 4'd1}; req_valid = 2'b11;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++; $display("FAIL arst_first_grant: got %b required 01", req_ready);
        end
        sb.push_back('{32'd1, 1'b0, 4'd1, 1'b0});
        @(negedge clk); req_valid = '0;
        cyc = 0;
        while (sb.size() != 0 && cyc < 200) begin @(negedge clk); cyc++; end
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL arst_drain: got %0d pending required 0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_negative();
        test_contention();
        test_backpressure();
        test_timeout();
        test_async_reset();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
